mem_access_ctrl: RTL
====================

# mem_access_ctrl

Memory-stage data-access controller for the LC-3b pipeline. It sequences single-phase loads, stores and trap-vector reads, and two-phase indirect loads and stores (LDI/STI), against the dcache. It steers addresses at or above a parametrised MMIO base to the performance-counter bank instead of the dcache. It drives the pipeline stall and the trap squash, and guards every cache access with a watchdog timeout.

## Interface
Parameters:
- AW, 16, address width; must be ≤ DW.
- DW, 16, data width.
- MMIO_BASE, 16'hFFF6, lowest MMIO address; accesses with addr ≥ MMIO_BASE use the counter bank.
- TIMEOUT, 64, maximum wait cycles for a dcache response; 0 disables the watchdog.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- valid  in  1  a valid instruction occupies the MEM stage.
- opcode  in  4  lc3b opcode of the MEM-stage instruction.
- ea  in  AW  effective address from EX/MEM.
- cache_rdata  in  DW  dcache read data.
- cache_resp  in  1  dcache acknowledge; one-cycle pulse; may arrive in the same cycle as req.
- mmio_rdata  in  DW  counter-bank read data for the current mem_addr.
- req  out  1  dcache request.
- we  out  1  dcache write enable; qualified by req.
- mem_addr  out  AW  address presented to the dcache and the counter bank.
- mmio_sel  out  1  access is currently served by the counter bank.
- mmio_we  out  1  counter-bank write strobe.
- rdata_out  out  DW  load data to MEM/WB: mmio_rdata when mmio_sel is high, else cache_rdata.
- stall  out  1  freeze PC and the IF/ID, ID/EX and EX/MEM registers.
- squash  out  1  flush the earlier stages; pulses when a trap completes.
- timeout_err  out  1  sticky flag; set when the watchdog fires.

## Operation
- Memory ops: single-phase are LDR, LDB, STR, STB, TRAP (TRAP reads). Two-phase are LDI (read, read) and STI (read, write). All other opcodes: no action; stall=0.
- FSM states:
  - IDLE
  - ACC1: first access pending.
  - ACC2: second access pending.
- In IDLE, the block latches opcode into op_q when valid and opcode is a memory op. In ACC1/ACC2, outputs use op_q, so ea and opcode changes are ignored. mem_addr = ea in IDLE/ACC1 and ptr_q in ACC2.
- IDLE, single-phase op:
  - ea ≥ MMIO_BASE: mmio_sel=1; mmio_we=1 for stores; completes this cycle; stall=0.
  - Otherwise: req=1, with we=1 for stores.
    - cache_resp in the same cycle: complete; stall=0.
    - Else: stall=1 and go to ACC1.
- ACC1: req held (we per op) until cache_resp; stall=1 until then.
  - Single-phase op: the response cycle completes the op; stall=0; go to IDLE.
- Two-phase op, phase 1 (from IDLE or ACC1): a read of the pointer at ea.
  - The source is MMIO (immediate) or the dcache (on cache_resp).
  - In the pointer-arrival cycle: ptr_q ← source[AW-1:0], stall=1, go to ACC2. The read data is not forwarded.
- ACC2: the access at ptr_q. we=1 for STI.
  - ptr_q ≥ MMIO_BASE: mmio_sel=1 (mmio_we for STI); complete immediately.
  - Otherwise: req until cache_resp, then complete.
  - Completion: stall=0, go to IDLE.
- squash = 1 in the completion cycle of TRAP only.
- Watchdog:
  - wait_cnt clears on entry to ACC1/ACC2 and increments each cycle req=1 without cache_resp.
  - At wait_cnt == TIMEOUT−1 with no response: set timeout_err, drop stall, go to IDLE, abort the op (no squash).
  - timeout_err clears only on rst.

## Timing
- Reset: state=IDLE, op_q=0, ptr_q=0, wait_cnt=0, timeout_err=0.
  - While rst is high: req, we, mmio_sel, mmio_we, stall and squash are 0.
  - Reset mid-operation abandons the access; no completion is reported.
- Outputs are combinational from state, op_q, ea, ptr_q and the response inputs. Registers update only at the clock edge.
- Latencies (stall cycles) with a cache response in cycle k after req first rises (k=0 means same cycle):
  - Single-phase cache op: k.
  - Single-phase MMIO op: 0.
  - LDI/STI, cache then cache: k1 + 1 + k2.
  - LDI/STI, with an MMIO pointer: k2 + 1.
  - LDI/STI, with an MMIO target: k1 + 1.
- cache_resp outside ACC1/ACC2, or outside an IDLE cycle with req=1, is ignored.
- Address compare is unsigned over AW bits; an address equal to MMIO_BASE is MMIO.
- Back-to-back ops: the completion cycle returns to IDLE, and the next instruction is evaluated in the following cycle.

## Test plan
- LDR ea=0x1000, resp 3 cycles after req -> req high for 4 cycles, stall high for 3 cycles, rdata_out=cache_rdata in the 4th cycle, no squash.
- STR ea=0x2000, resp in the same cycle -> req=we=1 for one cycle, stall never asserted.
- LDI ea=0x3000; pointer 0x4000 returned after 2 cycles; data after 1 cycle -> mem_addr 0x3000, then 0x4000; stall high for 4 cycles; ptr_q=0x4000.
- STI ea=0x3000 with pointer 0xFFF8 -> second access has mmio_sel=1, mmio_we=1, no second req; LDR ea=0xFFF6 -> mmio_sel=1, rdata_out=mmio_rdata, stall=0.
- TRAP ea=0x0040, resp after 1 cycle -> squash pulses exactly in the response cycle.
- TIMEOUT=4, LDR with no resp -> stall drops after 4 cycles, timeout_err=1 and held until rst; rst asserted in ACC2 -> all outputs 0 the next cycle.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: LC-3b MEM-stage data-access sequencer.
// Handles single-phase loads/stores/trap reads and two-phase LDI/STI against
// the dcache. Addresses at or above MMIO_BASE go to the counter bank instead.
// Drives the pipeline stall and trap squash. A watchdog bounds every dcache wait.
module mem_access_ctrl #(
    parameter int              AW        = 16,
    parameter int              DW        = 16,
    parameter logic [AW-1:0]   MMIO_BASE = AW'(16'hFFF6),
    parameter int              TIMEOUT   = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          valid,
    input  logic [3:0]    opcode,
    input  logic [AW-1:0] ea,
    input  logic [DW-1:0] cache_rdata,
    input  logic          cache_resp,
    input  logic [DW-1:0] mmio_rdata,
    output logic          req,
    output logic          we,
    output logic [AW-1:0] mem_addr,
    output logic          mmio_sel,
    output logic          mmio_we,
    output logic [DW-1:0] rdata_out,
    output logic          stall,
    output logic          squash,
    output logic          timeout_err
);

    localparam logic [3:0] OP_LDB  = 4'h2;
    localparam logic [3:0] OP_STB  = 4'h3;
    localparam logic [3:0] OP_LDR  = 4'h6;
    localparam logic [3:0] OP_STR  = 4'h7;
    localparam logic [3:0] OP_LDI  = 4'hA;
    localparam logic [3:0] OP_STI  = 4'hB;
    localparam logic [3:0] OP_TRAP = 4'hF;

    // Counter only needs to reach TIMEOUT-1; keep at least one bit when disabled.
    localparam int             CW        = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0]  WAIT_LAST = CW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

    typedef enum logic [1:0] {IDLE, ACC1, ACC2} state_t;

    state_t         state_reg, state_next;
    logic [3:0]     op_reg, op_next;
    logic [AW-1:0]  ptr_reg, ptr_next;
    logic [CW-1:0]  wait_cnt_reg, wait_cnt_next;
    logic           err_reg, err_next;

    logic           req_c, we_c, sel_c, mwe_c, stall_c, squash_c;
    logic [AW-1:0]  cur_addr;
    logic           addr_mmio;
    logic           wd_fire;

    function automatic logic is_single(input logic [3:0] op);
        return (op == OP_LDR) || (op == OP_LDB) || (op == OP_STR) ||
               (op == OP_STB) || (op == OP_TRAP);
    endfunction

    function automatic logic is_two(input logic [3:0] op);
        return (op == OP_LDI) || (op == OP_STI);
    endfunction

    // Only single-phase stores write in their (only) phase; STI writes in ACC2.
    function automatic logic is_store1(input logic [3:0] op);
        return (op == OP_STR) || (op == OP_STB);
    endfunction

    // Next-state and output decode: outputs are combinational from state and inputs.
    always_comb begin
        cur_addr      = (state_reg == ACC2) ? ptr_reg : ea;
        addr_mmio     = (cur_addr >= MMIO_BASE);
        wd_fire       = (TIMEOUT != 0) && (wait_cnt_reg == WAIT_LAST);
        req_c         = 1'b0;
        we_c          = 1'b0;
        sel_c         = 1'b0;
        mwe_c         = 1'b0;
        stall_c       = 1'b0;
        squash_c      = 1'b0;
        state_next    = state_reg;
        op_next       = op_reg;
        ptr_next      = ptr_reg;
        wait_cnt_next = wait_cnt_reg;
        err_next      = err_reg;
        case (state_reg)
            IDLE: begin
                if (valid && (is_single(opcode) || is_two(opcode))) begin
                    op_next = opcode;
                    if (addr_mmio) begin
                        sel_c = 1'b1;
                        if (is_two(opcode)) begin
                            // MMIO pointer arrives immediately; go fetch the target.
                            ptr_next      = mmio_rdata[AW-1:0];
                            stall_c       = 1'b1;
                            state_next    = ACC2;
                            wait_cnt_next = '0;
                        end else begin
                            mwe_c    = is_store1(opcode);
                            squash_c = (opcode == OP_TRAP);
                        end
                    end else begin
                        req_c = 1'b1;
                        we_c  = is_store1(opcode);
                        if (cache_resp) begin
                            if (is_two(opcode)) begin
                                ptr_next      = cache_rdata[AW-1:0];
                                stall_c       = 1'b1;
                                state_next    = ACC2;
                                wait_cnt_next = '0;
                            end else begin
                                squash_c = (opcode == OP_TRAP);
                            end
                        end else begin
                            stall_c       = 1'b1;
                            state_next    = ACC1;
                            wait_cnt_next = '0;
                        end
                    end
                end
            end
            ACC1: begin
                req_c = 1'b1;
                we_c  = is_store1(op_reg);
                if (cache_resp) begin
                    if (is_two(op_reg)) begin
                        ptr_next      = cache_rdata[AW-1:0];
                        stall_c       = 1'b1;
                        state_next    = ACC2;
                        wait_cnt_next = '0;
                    end else begin
                        squash_c   = (op_reg == OP_TRAP);
                        state_next = IDLE;
                    end
                end else if (wd_fire) begin
                    err_next   = 1'b1;
                    state_next = IDLE;
                end else begin
                    stall_c       = 1'b1;
                    wait_cnt_next = wait_cnt_reg + CW'(1);
                end
            end
            ACC2: begin
                if (addr_mmio) begin
                    sel_c      = 1'b1;
                    mwe_c      = (op_reg == OP_STI);
                    state_next = IDLE;
                end else begin
                    req_c = 1'b1;
                    we_c  = (op_reg == OP_STI);
                    if (cache_resp) begin
                        state_next = IDLE;
                    end else if (wd_fire) begin
                        err_next   = 1'b1;
                        state_next = IDLE;
                    end else begin
                        stall_c       = 1'b1;
                        wait_cnt_next = wait_cnt_reg + CW'(1);
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State registers; reset abandons any access in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            op_reg       <= '0;
            ptr_reg      <= '0;
            wait_cnt_reg <= '0;
            err_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            op_reg       <= op_next;
            ptr_reg      <= ptr_next;
            wait_cnt_reg <= wait_cnt_next;
            err_reg      <= err_next;
        end
    end

    assign req         = !rst && req_c;
    assign we          = !rst && we_c;
    assign mmio_sel    = !rst && sel_c;
    assign mmio_we     = !rst && mwe_c;
    assign stall       = !rst && stall_c;
    assign squash      = !rst && squash_c;
    assign mem_addr    = cur_addr;
    assign rdata_out   = mmio_sel ? mmio_rdata : cache_rdata;
    assign timeout_err = err_reg;

endmodule
